// File: rtl/imem_responder.sv
// Instruction-memory responder: single-outstanding fetch port with
// configurable wait states, preload write port and flush support.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic        rsp_fault,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [3:0] WAIT_INIT =
    4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  logic [31:0] mem [DEPTH_WORDS];

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_instr_q, rsp_instr_d;
  logic          rsp_fault_q, rsp_fault_d;

  logic [AW-1:0] req_idx;
  logic          req_bad;
  logic          ld_oor;
  logic          accept;
  logic          unused_ld_lsb;

  // Range check uses the full word index before truncation.
  assign req_idx = req_addr[AW+1:2];
  assign req_bad = (|req_addr[1:0]) | (|req_addr[31:AW+2]);
  assign ld_oor  = |ld_addr[31:AW+2];
  assign unused_ld_lsb = ^ld_addr[1:0];

  assign req_ready = rstn && (state_q == IDLE) && !flush;
  assign accept    = req_valid && req_ready;

  assign rsp_valid = rsp_valid_q;
  assign rsp_instr = rsp_instr_q;
  assign rsp_fault = rsp_fault_q;

  always_ff @(posedge clk) begin
    if (ld_en && !ld_oor) begin
      mem[ld_addr[AW+1:2]] <= ld_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rsp_valid_d = rsp_valid_q;
    rsp_instr_d = rsp_instr_q;
    rsp_fault_d = rsp_fault_q;
    if (flush) begin
      state_d     = IDLE;
      cnt_d       = 4'd0;
      rsp_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            idx_d = req_idx;
            if (req_bad) begin
              state_d     = RESP;
              rsp_valid_d = 1'b1;
              rsp_instr_d = NOP;
              rsp_fault_d = 1'b1;
            end else if (WAIT_STATES == 0) begin
              state_d     = RESP;
              rsp_valid_d = 1'b1;
              rsp_instr_d = mem[req_idx];
              rsp_fault_d = 1'b0;
            end else begin
              state_d = WAIT;
              cnt_d   = WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_instr_d = mem[idx_q];
            rsp_fault_d = 1'b0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= 32'd0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: a 2-wait-state/1024-word instance
// and a zero-wait/16-word instance.
module tb_imem_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;

  logic        a_req_valid, a_req_ready, a_flush;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_fault, a_ld_en;
  logic [31:0] a_req_addr, a_rsp_instr, a_ld_addr, a_ld_data;

  logic        b_req_valid, b_req_ready, b_flush;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_fault, b_ld_en;
  logic [31:0] b_req_addr, b_rsp_instr, b_ld_addr, b_ld_data;

  imem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_a (
    .clk(clk), .rstn(rstn),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_addr(a_req_addr), .flush(a_flush),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_instr(a_rsp_instr), .rsp_fault(a_rsp_fault),
    .ld_en(a_ld_en), .ld_addr(a_ld_addr), .ld_data(a_ld_data)
  );

  imem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(0)) u_b (
    .clk(clk), .rstn(rstn),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_addr(b_req_addr), .flush(b_flush),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_instr(b_rsp_instr), .rsp_fault(b_rsp_fault),
    .ld_en(b_ld_en), .ld_addr(b_ld_addr), .ld_data(b_ld_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] amem [1024];
  logic [31:0] bmem [16];
  logic [32:0] exp_a [$];
  logic [32:0] exp_b [$];

  function automatic logic [32:0] a_model(input logic [31:0] addr);
    if (addr[1:0] != 2'd0 || addr[31:12] != 20'd0) return {1'b1, NOP};
    return {1'b0, amem[addr[11:2]]};
  endfunction

  function automatic logic [32:0] b_model(input logic [31:0] addr);
    if (addr[1:0] != 2'd0 || addr[31:6] != 26'd0) return {1'b1, NOP};
    return {1'b0, bmem[addr[5:2]]};
  endfunction

  task automatic a_load(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    a_ld_en = 1'b1;
    a_ld_addr = addr;
    a_ld_data = data;
    @(negedge clk);
    a_ld_en = 1'b0;
    if (addr[31:12] == 20'd0) amem[addr[11:2]] = data;
  endtask

  task automatic b_load(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    b_ld_en = 1'b1;
    b_ld_addr = addr;
    b_ld_data = data;
    @(negedge clk);
    b_ld_en = 1'b0;
    if (addr[31:6] == 26'd0) bmem[addr[5:2]] = data;
  endtask

  // Returns at the falling edge right after the accept edge.
  task automatic a_send(input logic [31:0] addr);
    @(negedge clk);
    a_req_valid = 1'b1;
    a_req_addr = addr;
    exp_a.push_back(a_model(addr));
    @(negedge clk);
    a_req_valid = 1'b0;
  endtask

  task automatic a_wait(output int k);
    k = 0;
    while (!a_rsp_valid && k < 8) begin
      @(negedge clk);
      k++;
    end
    if (!a_rsp_valid) k = -1;
  endtask

  task automatic a_ack();
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
  endtask

  function automatic logic [32:0] a_pop();
    if (exp_a.size() == 0) return 33'h0;
    return exp_a.pop_front();
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    a_req_valid = 0; a_req_addr = 0; a_flush = 0; a_rsp_ready = 0;
    a_ld_en = 0; a_ld_addr = 0; a_ld_data = 0;
    b_req_valid = 0; b_req_addr = 0; b_flush = 0; b_rsp_ready = 0;
    b_ld_en = 0; b_ld_addr = 0; b_ld_data = 0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (a_rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_valid got %b want 0", a_rsp_valid);
    end
    n_cmp++;
    if (a_rsp_instr !== 32'd0) begin
      n_bad++; $display("FAIL rst_instr got %h want 0", a_rsp_instr);
    end
    n_cmp++;
    if (a_rsp_fault !== 1'b0) begin
      n_bad++; $display("FAIL rst_fault got %b want 0", a_rsp_fault);
    end
    n_cmp++;
    if (a_req_ready !== 1'b0 || b_req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_ready got %b/%b want 0/0", a_req_ready, b_req_ready);
    end
    rstn = 1'b1;
    #1;
    n_cmp++;
    if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rel_ready got %b/%b want 1/1", a_req_ready, b_req_ready);
    end
  endtask

  task automatic test_basic();
    int k;
    logic [32:0] e;
    a_load(32'h10, 32'h00A0_0093);
    a_send(32'h10);
    a_wait(k);
    n_cmp++;
    if (k !== 2) begin
      n_bad++; $display("FAIL basic_lat got %0d want 2", k);
    end
    e = a_pop();
    n_cmp++;
    if ({a_rsp_fault, a_rsp_instr} !== e || e[31:0] !== 32'h00A0_0093) begin
      n_bad++;
      $display("FAIL basic_data got %b/%h want %b/%h",
               a_rsp_fault, a_rsp_instr, e[32], e[31:0]);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (a_rsp_valid !== 1'b1 || {a_rsp_fault, a_rsp_instr} !== e) begin
        n_bad++;
        $display("FAIL hold_%0d got %b/%b/%h want 1/%b/%h", i,
                 a_rsp_valid, a_rsp_fault, a_rsp_instr, e[32], e[31:0]);
      end
      n_cmp++;
      if (a_req_ready !== 1'b0) begin
        n_bad++; $display("FAIL resp_ready_%0d got %b want 0", i, a_req_ready);
      end
    end
    a_ack();
    n_cmp++;
    if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL post_ack got v=%b r=%b want v=0 r=1",
               a_rsp_valid, a_req_ready);
    end
  endtask

  task automatic test_fault();
    int k;
    logic [32:0] e;
    a_send(32'h12);
    a_wait(k);
    e = a_pop();
    n_cmp++;
    if (k !== 0 || {a_rsp_fault, a_rsp_instr} !== e) begin
      n_bad++;
      $display("FAIL misalign got lat=%0d %b/%h want lat=0 %b/%h",
               k, a_rsp_fault, a_rsp_instr, e[32], e[31:0]);
    end
    a_ack();
    a_send(32'h1000);
    a_wait(k);
    e = a_pop();
    n_cmp++;
    if (k !== 0 || {a_rsp_fault, a_rsp_instr} !== e) begin
      n_bad++;
      $display("FAIL oor got lat=%0d %b/%h want lat=0 %b/%h",
               k, a_rsp_fault, a_rsp_instr, e[32], e[31:0]);
    end
    a_ack();
    a_load(32'hFFC, 32'hCAFE_0FFC);
    a_send(32'hFFC);
    a_wait(k);
    e = a_pop();
    n_cmp++;
    if (k !== 2 || {a_rsp_fault, a_rsp_instr} !== e) begin
      n_bad++;
      $display("FAIL last_word got lat=%0d %b/%h want lat=2 %b/%h",
               k, a_rsp_fault, a_rsp_instr, e[32], e[31:0]);
    end
    a_ack();
  endtask

  task automatic test_flush();
    int k;
    logic seen;
    logic [32:0] e;
    a_load(32'h0, 32'h0010_0113);
    a_send(32'h10);
    a_flush = 1'b1;
    @(negedge clk);
    a_flush = 1'b0;
    void'(a_pop());
    #1;
    n_cmp++;
    if (a_req_ready !== 1'b1) begin
      n_bad++; $display("FAIL flush_ready got %b want 1", a_req_ready);
    end
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (a_rsp_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL flush_ghost got 1 want 0");
    end
    a_send(32'h0);
    a_wait(k);
    e = a_pop();
    n_cmp++;
    if (k !== 2 || {a_rsp_fault, a_rsp_instr} !== e) begin
      n_bad++;
      $display("FAIL post_flush got lat=%0d %b/%h want lat=2 %b/%h",
               k, a_rsp_fault, a_rsp_instr, e[32], e[31:0]);
    end
    a_ack();
    a_send(32'h4);
    a_wait(k);
    void'(a_pop());
    a_flush = 1'b1;
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_flush = 1'b0;
    a_rsp_ready = 1'b0;
    #1;
    n_cmp++;
    if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_resp got v=%b r=%b want v=0 r=1",
               a_rsp_valid, a_req_ready);
    end
  endtask

  task automatic test_ld_collision();
    int k;
    logic [32:0] e;
    a_send(32'h10);
    @(negedge clk);
    a_ld_en = 1'b1;
    a_ld_addr = 32'h12;
    a_ld_data = 32'h00B0_0113;
    @(negedge clk);
    a_ld_en = 1'b0;
    amem[4] = 32'h00B0_0113;
    e = a_pop();
    n_cmp++;
    if (a_rsp_valid !== 1'b1 || a_rsp_instr !== e[31:0]) begin
      n_bad++;
      $display("FAIL coll_old got v=%b %h want v=1 %h",
               a_rsp_valid, a_rsp_instr, e[31:0]);
    end
    a_ack();
    a_send(32'h10);
    a_wait(k);
    e = a_pop();
    n_cmp++;
    if (k !== 2 || {a_rsp_fault, a_rsp_instr} !== e) begin
      n_bad++;
      $display("FAIL coll_new got %b/%h want %b/%h",
               a_rsp_fault, a_rsp_instr, e[32], e[31:0]);
    end
    a_ack();
    a_load(32'h1000, 32'hDEAD_BEEF);
    a_send(32'h0);
    a_wait(k);
    e = a_pop();
    n_cmp++;
    if (k !== 2 || {a_rsp_fault, a_rsp_instr} !== e) begin
      n_bad++;
      $display("FAIL oor_write got %b/%h want %b/%h",
               a_rsp_fault, a_rsp_instr, e[32], e[31:0]);
    end
    a_ack();
  endtask

  task automatic test_reset_resp();
    int k;
    logic seen;
    a_send(32'h10);
    a_wait(k);
    void'(a_pop());
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({a_rsp_valid, a_rsp_fault, a_rsp_instr, a_req_ready} !== 35'd0) begin
      n_bad++;
      $display("FAIL rst_resp got v=%b f=%b i=%h r=%b want all 0",
               a_rsp_valid, a_rsp_fault, a_rsp_instr, a_req_ready);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    n_cmp++;
    if (a_req_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_rel_ready got %b want 1", a_req_ready);
    end
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (a_rsp_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL rst_stale got 1 want 0");
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [8];
    logic [32:0] e;
    int sent, got, last, cyc;
    addrs = '{32'h0, 32'h4, 32'h8, 32'h3C, 32'h40, 32'h6, 32'hC, 32'h0};
    for (int i = 0; i < 16; i++) begin
      b_load(32'(i * 4), 32'h1000_0000 + 32'(i) * 32'h111);
    end
    b_load(32'h40, 32'hBADB_AD00);
    b_rsp_ready = 1'b1;
    sent = 0; got = 0; last = -1; cyc = 0;
    while (got < 8 && cyc < 100) begin
      @(negedge clk);
      if (b_rsp_valid) begin
        e = (exp_b.size() != 0) ? exp_b.pop_front() : 33'h0;
        n_cmp++;
        if ({b_rsp_fault, b_rsp_instr} !== e) begin
          n_bad++;
          $display("FAIL b2b_data_%0d got %b/%h want %b/%h", got,
                   b_rsp_fault, b_rsp_instr, e[32], e[31:0]);
        end
        if (last >= 0) begin
          n_cmp++;
          if (cyc - last !== 2) begin
            n_bad++;
            $display("FAIL b2b_gap_%0d got %0d want 2", got, cyc - last);
          end
        end
        last = cyc;
        got++;
      end
      if (b_req_ready) begin
        if (sent < 8) begin
          b_req_valid = 1'b1;
          b_req_addr = addrs[sent];
          exp_b.push_back(b_model(addrs[sent]));
          sent++;
        end else begin
          b_req_valid = 1'b0;
        end
      end
      cyc++;
    end
    b_req_valid = 1'b0;
    n_cmp++;
    if (got !== 8 || exp_b.size() !== 0) begin
      n_bad++;
      $display("FAIL b2b_count got %0d left %0d want 8 left 0",
               got, exp_b.size());
    end
    b_rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_fault();
    test_flush();
    test_ld_collision();
    test_reset_resp();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
